// File: rtl/morse_game_ctrl.sv
// Two-player morse spy-game control on a single clock qualified by tick.
// Player 1 keys a message into a symbol buffer; player 2 replays it and is
// scored symbol by symbol with a miss limit and an inactivity timeout.
module morse_game_ctrl #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DASH_TICKS    = 2,
    parameter int unsigned TIMEOUT_TICKS = 10,
    parameter int unsigned MAX_MISS      = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              tick,
    input  logic              key_in,
    input  logic              next_in,
    input  logic              done_in,
    output logic [1:0]        state,
    output logic              sym_valid,
    output logic [1:0]        sym,
    output logic [ADDR_W:0]   wr_count,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              match,
    output logic              mismatch,
    output logic [1:0]        miss_count,
    output logic              overflow,
    output logic              win,
    output logic              lose
);

    localparam int unsigned HOLD_W = $clog2(DASH_TICKS + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b11;
    localparam logic [1:0] SYM_SEP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_P1     = 2'd1,
        ST_P2     = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                key_q;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                sym_valid_q, sym_valid_d;
    logic [1:0]          sym_q, sym_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                match_q, match_d;
    logic                mismatch_q, mismatch_d;
    logic [1:0]          miss_count_q, miss_count_d;
    logic                overflow_q, overflow_d;
    logic                win_q, win_d;
    logic                lose_q, lose_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

    logic [1:0]          mem_q [DEPTH];
    logic                mem_we;

    logic                cls_en;
    logic                press_ev;
    logic                release_ev;
    logic [ADDR_W:0]     wr_next;
    logic [ADDR_W:0]     rd_inc;
    logic [IDLE_W:0]     idle_inc;
    logic [2:0]          miss_inc;
    logic                miss_ev;

    // Press classifier: hold timing and dot/dash/separator pulse generation
    always_comb begin
        cls_en      = (state_q == ST_P1) || (state_q == ST_P2);
        press_ev    = key_in & ~key_q;
        release_ev  = key_q & ~key_in;
        hold_cnt_d  = hold_cnt_q;
        sym_valid_d = 1'b0;
        sym_d       = sym_q;

        if (press_ev) begin
            hold_cnt_d = '0;
        end else if (key_q && key_in && tick && (hold_cnt_q < HOLD_W'(DASH_TICKS))) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end

        // A release outranks a simultaneous separator, which is dropped
        if (cls_en) begin
            if (release_ev) begin
                sym_valid_d = 1'b1;
                sym_d       = (hold_cnt_q >= HOLD_W'(DASH_TICKS)) ? SYM_DASH : SYM_DOT;
            end else if (next_in) begin
                sym_valid_d = 1'b1;
                sym_d       = SYM_SEP;
            end
        end
    end

    // Game FSM: phase sequencing, P1 storage and P2 scoring
    always_comb begin
        state_d      = state_q;
        wr_count_d   = wr_count_q;
        rd_addr_d    = rd_addr_q;
        match_d      = 1'b0;
        mismatch_d   = 1'b0;
        miss_count_d = miss_count_q;
        overflow_d   = overflow_q;
        win_d        = win_q;
        lose_d       = lose_q;
        idle_cnt_d   = idle_cnt_q;
        mem_we       = 1'b0;
        wr_next      = wr_count_q;
        rd_inc       = {1'b0, rd_addr_q} + (ADDR_W+1)'(1);
        idle_inc     = {1'b0, idle_cnt_q} + (IDLE_W+1)'(1);
        miss_inc     = {1'b0, miss_count_q} + 3'd1;
        miss_ev      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (done_in) begin
                    state_d      = ST_P1;
                    wr_count_d   = '0;
                    rd_addr_d    = '0;
                    miss_count_d = '0;
                    overflow_d   = 1'b0;
                    win_d        = 1'b0;
                    lose_d       = 1'b0;
                end
            end

            ST_P1: begin
                if (sym_valid_q) begin
                    if (wr_count_q == (ADDR_W+1)'(DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        wr_next = wr_count_q + (ADDR_W+1)'(1);
                    end
                end
                wr_count_d = wr_next;
                // Same-cycle symbol is counted before the empty-message check
                if (done_in && (wr_next != '0)) begin
                    state_d    = ST_P2;
                    idle_cnt_d = '0;
                end
            end

            ST_P2: begin
                if (sym_valid_q) begin
                    idle_cnt_d = '0;
                    if (sym_q == mem_q[rd_addr_q]) begin
                        match_d = 1'b1;
                        if (rd_inc == wr_count_q) begin
                            state_d = ST_RESULT;
                            win_d   = 1'b1;
                        end else begin
                            rd_addr_d = rd_inc[ADDR_W-1:0];
                        end
                    end else begin
                        miss_ev = 1'b1;
                    end
                end else if (tick) begin
                    if (idle_inc == (IDLE_W+1)'(TIMEOUT_TICKS)) begin
                        miss_ev    = 1'b1;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_inc[IDLE_W-1:0];
                    end
                end

                if (miss_ev) begin
                    mismatch_d   = 1'b1;
                    miss_count_d = (miss_inc > 3'd3) ? 2'b11 : miss_inc[1:0];
                    if (miss_inc == 3'(MAX_MISS)) begin
                        state_d = ST_RESULT;
                        lose_d  = 1'b1;
                    end
                end

                // Giving up loses unless the same-cycle comparison just won
                if (done_in && !win_d) begin
                    state_d = ST_RESULT;
                    lose_d  = 1'b1;
                end
            end

            ST_RESULT: begin
                if (done_in) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            key_q        <= 1'b0;
            hold_cnt_q   <= '0;
            sym_valid_q  <= 1'b0;
            sym_q        <= '0;
            wr_count_q   <= '0;
            rd_addr_q    <= '0;
            match_q      <= 1'b0;
            mismatch_q   <= 1'b0;
            miss_count_q <= '0;
            overflow_q   <= 1'b0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_in;
            hold_cnt_q   <= hold_cnt_d;
            sym_valid_q  <= sym_valid_d;
            sym_q        <= sym_d;
            wr_count_q   <= wr_count_d;
            rd_addr_q    <= rd_addr_d;
            match_q      <= match_d;
            mismatch_q   <= mismatch_d;
            miss_count_q <= miss_count_d;
            overflow_q   <= overflow_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    // Symbol buffer write port; contents survive reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_count_q[ADDR_W-1:0]] <= sym_q;
        end
    end

    assign state      = state_q;
    assign sym_valid  = sym_valid_q;
    assign sym        = sym_q;
    assign wr_count   = wr_count_q;
    assign rd_addr    = rd_addr_q;
    assign match      = match_q;
    assign mismatch   = mismatch_q;
    assign miss_count = miss_count_q;
    assign overflow   = overflow_q;
    assign win        = win_q;
    assign lose       = lose_q;

endmodule

// File: tb/tb_morse_game_ctrl.sv
// Directed scoreboard bench for morse_game_ctrl.
module tb_morse_game_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       tick;
    logic       key_in;
    logic       next_in;
    logic       done_in;
    logic [1:0] state;
    logic       sym_valid;
    logic [1:0] sym;
    logic [4:0] wr_count;
    logic [3:0] rd_addr;
    logic       match;
    logic       mismatch;
    logic [1:0] miss_count;
    logic       overflow;
    logic       win;
    logic       lose;

    logic [1:0] sym_exp[$];
    bit         res_exp[$];
    int         total = 0;
    int         bad   = 0;

    always #5 clock = ~clock;

    morse_game_ctrl #(
        .DEPTH(16),
        .ADDR_W(4),
        .DASH_TICKS(2),
        .TIMEOUT_TICKS(10),
        .MAX_MISS(3)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .tick(tick),
        .key_in(key_in),
        .next_in(next_in),
        .done_in(done_in),
        .state(state),
        .sym_valid(sym_valid),
        .sym(sym),
        .wr_count(wr_count),
        .rd_addr(rd_addr),
        .match(match),
        .mismatch(mismatch),
        .miss_count(miss_count),
        .overflow(overflow),
        .win(win),
        .lose(lose)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop scoreboard entries whenever the DUT emits a symbol or a score pulse
    task automatic check_outputs();
        logic [1:0] e_sym;
        bit         e_res;
        if (sym_valid === 1'b1) begin
            if (sym_exp.size() == 0) begin
                chk("sym_unexpected", 32'(sym_valid), 32'd0);
            end else begin
                e_sym = sym_exp.pop_front();
                chk("sym", 32'(sym), 32'(e_sym));
            end
        end
        if (match === 1'b1 || mismatch === 1'b1) begin
            if (res_exp.size() == 0) begin
                chk("res_unexpected", 32'({match, mismatch}), 32'd0);
            end else begin
                e_res = res_exp.pop_front();
                chk("res", 32'({match, mismatch}), e_res ? 32'd2 : 32'd1);
            end
        end
    endtask

    task automatic clk1(input bit t);
        tick = t;
        @(posedge clock);
        #1;
        tick    = 1'b0;
        next_in = 1'b0;
        done_in = 1'b0;
        check_outputs();
    endtask

    task automatic press(input int unsigned n, input logic [1:0] exp_sym);
        key_in = 1'b1;
        clk1(1'b0);
        for (int unsigned i = 0; i < n; i++) clk1(1'b1);
        key_in = 1'b0;
        sym_exp.push_back(exp_sym);
        clk1(1'b0);
    endtask

    task automatic sep();
        next_in = 1'b1;
        sym_exp.push_back(2'b10);
        clk1(1'b0);
    endtask

    task automatic done_pulse();
        done_in = 1'b1;
        clk1(1'b0);
    endtask

    initial begin
        resetn  = 1'b0;
        tick    = 1'b0;
        key_in  = 1'b0;
        next_in = 1'b0;
        done_in = 1'b0;
        repeat (3) clk1(1'b0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_sym", 32'(sym), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_match", 32'({match, mismatch}), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        chk("rst_flags", 32'({overflow, win, lose}), 32'd0);
        resetn = 1'b1;
        clk1(1'b0);

        // Round 1: P1 keys dot, dash, separator; P2 replays correctly
        done_pulse();
        chk("idle_to_p1", 32'(state), 32'd1);
        done_pulse();
        chk("p1_empty_done_ignored", 32'(state), 32'd1);
        press(1, 2'b01);
        press(3, 2'b11);
        sep();
        clk1(1'b0);
        chk("p1_wr_count3", 32'(wr_count), 32'd3);
        done_pulse();
        chk("p1_to_p2", 32'(state), 32'd2);

        press(1, 2'b01);
        res_exp.push_back(1'b1);
        clk1(1'b0);
        chk("p2_rd1", 32'(rd_addr), 32'd1);
        press(3, 2'b11);
        res_exp.push_back(1'b1);
        clk1(1'b0);
        chk("p2_rd2", 32'(rd_addr), 32'd2);
        sep();
        res_exp.push_back(1'b1);
        clk1(1'b0);
        chk("win_state", 32'(state), 32'd3);
        chk("win_flags", 32'({win, lose}), 32'd2);
        chk("win_rd_hold", 32'(rd_addr), 32'd2);
        done_pulse();
        chk("result_to_idle", 32'(state), 32'd0);
        chk("win_held_idle", 32'(win), 32'd1);
        done_pulse();
        chk("p1_entry_clear", 32'({win, lose, overflow}), 32'd0);
        chk("p1_entry_wr", 32'(wr_count), 32'd0);

        // Round 2: stored dot, P2 answers three dashes and loses
        press(1, 2'b01);
        clk1(1'b0);
        done_pulse();
        chk("r2_p2", 32'(state), 32'd2);
        for (int unsigned k = 0; k < 3; k++) begin
            press(3, 2'b11);
            res_exp.push_back(1'b0);
            clk1(1'b0);
            if (k == 0) chk("r2_miss1", 32'(miss_count), 32'd1);
        end
        chk("r2_state", 32'(state), 32'd3);
        chk("r2_rd", 32'(rd_addr), 32'd0);
        chk("r2_miss3", 32'(miss_count), 32'd3);
        chk("r2_flags", 32'({win, lose}), 32'd1);
        done_pulse();
        done_pulse();

        // Round 3: overflow, timeout, release colliding with next_in
        for (int unsigned k = 0; k < 17; k++) sep();
        clk1(1'b0);
        chk("ovf_wr", 32'(wr_count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        done_pulse();
        chk("r3_p2", 32'(state), 32'd2);
        repeat (9) clk1(1'b1);
        chk("timeout_early", 32'(miss_count), 32'd0);
        res_exp.push_back(1'b0);
        clk1(1'b1);
        chk("timeout_miss", 32'(miss_count), 32'd1);
        chk("timeout_rd", 32'(rd_addr), 32'd0);

        key_in = 1'b1;
        clk1(1'b0);
        key_in  = 1'b0;
        next_in = 1'b1;
        sym_exp.push_back(2'b01);
        clk1(1'b0);
        res_exp.push_back(1'b0);
        clk1(1'b0);
        clk1(1'b0);
        chk("collide_miss", 32'(miss_count), 32'd2);
        chk("collide_state", 32'(state), 32'd2);

        // Asynchronous reset in the middle of P2
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        clk1(1'b0);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_miss", 32'(miss_count), 32'd0);
        chk("midrst_pulses", 32'({match, mismatch}), 32'd0);
        chk("midrst_sym", 32'(sym), 32'd0);
        resetn = 1'b1;
        clk1(1'b0);

        // Round 4: give up in P2
        done_pulse();
        press(1, 2'b01);
        clk1(1'b0);
        done_pulse();
        chk("r4_p2", 32'(state), 32'd2);
        done_pulse();
        chk("giveup_state", 32'(state), 32'd3);
        chk("giveup_flags", 32'({win, lose}), 32'd1);

        clk1(1'b0);
        chk("sym_queue_drained", 32'(sym_exp.size()), 32'd0);
        chk("res_queue_drained", 32'(res_exp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_game_ctrl.md
Name: morse_game_ctrl

Overview:
- Parametrised successor to the two-player morse spy-game top-level control.
- Runs entirely on one system clock, qualified by a `tick` enable, instead of derived clocks.
- Classifies key presses into dot/dash by duration and stores player 1's message in an internal symbol buffer of configurable depth.
- Scores player 2's replay symbol by symbol, with a miss limit and an inactivity timeout. Feeds HEX/LED/VGA display logic.

Parameters:
- DEPTH, 16: symbol buffer entries (power of two).
- ADDR_W, 4: log2(DEPTH).
- DASH_TICKS, 2: ticks held at or above which a press is a dash.
- TIMEOUT_TICKS, 10: idle ticks in P2 that count as one miss.
- MAX_MISS, 3: misses that end the round as a loss.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle enable pulse from rate_divider.
- key_in  in  1  morse key, active-high pressed, already synchronised.
- next_in  in  1  one-cycle pulse: letter separator.
- done_in  in  1  one-cycle pulse: advance phase.
- state  out  2  0=IDLE 1=P1 2=P2 3=RESULT.
- sym_valid  out  1  one-cycle pulse: new symbol classified.
- sym  out  2  last symbol: 01 dot, 11 dash, 10 separator, 00 none.
- wr_count  out  ADDR_W+1  symbols stored by P1.
- rd_addr  out  ADDR_W  P2 compare pointer.
- match  out  1  one-cycle pulse: P2 symbol correct.
- mismatch  out  1  one-cycle pulse: P2 symbol wrong or timeout.
- miss_count  out  2  misses this round, saturating.
- overflow  out  1  sticky: P1 symbol dropped because buffer full.
- win  out  1  level, valid in RESULT.
- lose  out  1  level, valid in RESULT.

Behaviour:
- Reset (asynchronous, any time, including mid-round):
  - state=IDLE; all outputs, counters and flags = 0; sym=00.
  - Buffer contents need not be cleared.
- Press classifier (active in P1 and P2 only):
  - key_in is registered. hold_cnt clears on press, increments on each tick while held, and saturates at DASH_TICKS.
  - Release (registered key 1 -> 0) produces sym_valid in the next cycle. sym=11 if hold_cnt >= DASH_TICKS, else 01; a zero-tick press gives a dot.
  - A tick coinciding with the release cycle is ignored.
  - next_in produces sym_valid with sym=10 in the next cycle.
  - If a release and next_in occur together, the key symbol wins and next_in is dropped.
- IDLE:
  - done_in -> P1. On entry, clear wr_count, rd_addr, miss_count, overflow, win and lose.
- P1:
  - Each sym_valid writes sym to mem[wr_count] and increments wr_count.
  - If wr_count==DEPTH, the symbol is dropped and overflow is set.
  - done_in -> P2 only if wr_count!=0; otherwise done_in is ignored.
  - A symbol and done_in in the same cycle: the symbol is written first, then the transition is taken.
- P2 (comparison registered; match/mismatch pulse one cycle after sym_valid):
  - Equal to mem[rd_addr]:
    - Pulse match and increment rd_addr.
    - If rd_addr+1==wr_count -> RESULT with win=1.
  - Not equal:
    - Pulse mismatch, increment miss_count, leave rd_addr unchanged.
    - If miss_count+1==MAX_MISS -> RESULT with lose=1.
  - idle_cnt counts ticks and clears on each sym_valid and on P2 entry. Reaching TIMEOUT_TICKS is treated as a miss (same rules), then idle_cnt clears.
  - done_in -> RESULT with lose=1 (give up). A same-cycle comparison is applied first; if that comparison wins, the win stands.
- RESULT:
  - win/lose held; classifier disabled.
  - done_in -> IDLE; win/lose stay held until the next P1 entry.
- All arithmetic is unsigned. rd_addr never exceeds wr_count-1.

Test Plan:
- Reset mid-P2 with miss_count=2 -> next cycle state=0, miss_count=0, match=mismatch=0, sym=00.
- IDLE done, P1: press 1 tick, press 3 ticks, next_in, done -> wr_count=3; mem = 01, 11, 10; state=2.
- P2 replays dot, dash, separator -> three match pulses, rd_addr 0 -> 1 -> 2, then state=3, win=1.
- P2 enters dash, dash, dash against stored dot -> three mismatch pulses, rd_addr=0, miss_count=3, lose=1.
- P1 enters 17 symbols with DEPTH=16 -> wr_count=16, overflow=1. P2 no input for 10 ticks -> mismatch pulse, miss_count=1.
- done_in in P1 with wr_count=0 -> stays in state 1. Release and next_in in the same cycle -> single sym_valid carrying the key symbol.
